au_encode_seq: RTL and testbench



---
 rtl/au_encode_pkg.sv | 29 ++
 rtl/au_encode_slice.sv | 37 +++
 rtl/au_encode_seq.sv | 167 ++++++++++++++++
 tb/tb_au_encode_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/au_encode_pkg.sv
// Shared types and elaboration helpers for the sequential one-hot encoder.
// Contents: scan FSM state enum, scan-cycle count function and a
// WIDTH/SLICE legality check evaluated at elaboration time.
package au_encode_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of scan cycles needed to cover a 2**width-bit word.
    function automatic int unsigned scan_count(input int unsigned width,
                                               input int unsigned slice);
        return (32'(1) << width) / slice;
    endfunction

    // WIDTH in 1..8; SLICE a power of two no larger than the word, which
    // also guarantees it divides the word evenly.
    function automatic bit params_ok(input int unsigned width,
                                     input int unsigned slice);
        bit ok;
        ok = (width >= 1) && (width <= 8);
        ok = ok && (slice >= 1) && (slice <= (32'(1) << width));
        ok = ok && ((slice & (slice - 32'(1))) == 32'(0));
        return ok;
    endfunction

endpackage

// File: rtl/au_encode_slice.sv
// Combinational SLICE-bit priority encoder used by the scanning encoder.
// Ports:
//   chunk    - SLICE-bit slice of the input word
//   idx_c    - local index of the highest set bit (0 when none set)
//   any_c    - at least one bit of the chunk is set
//   multi_c  - two or more bits of the chunk are set
module au_encode_slice
    import au_encode_pkg::*;
#(
    parameter int unsigned SLICE = 2
) (
    input  logic [SLICE-1:0]                      chunk,
    output logic [((SLICE > 1) ? $clog2(SLICE) : 1)-1:0] idx_c,
    output logic                                  any_c,
    output logic                                  multi_c
);

    localparam int unsigned LW = (SLICE > 1) ? $clog2(SLICE) : 1;

    logic [SLICE-1:0] lower;

    // Highest set bit wins because later iterations overwrite earlier ones.
    always_comb begin
        idx_c = '0;
        for (int unsigned i = 0; i < SLICE; i++) begin
            if (chunk[i]) begin
                idx_c = LW'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign lower   = chunk - SLICE'(1);
    assign any_c   = |chunk;
    assign multi_c = |(chunk & lower);

endmodule

// File: rtl/au_encode_seq.sv
// Sequential one-hot-to-binary priority encoder (inverse of AU decode).
// Scans a 2**WIDTH-bit word SLICE bits per clock, low chunk first, and
// reports the highest set bit index plus zero / multi-hot flags.
// Ports:
//   clk, rst_n          - clock and synchronous active-low reset
//   in_valid, in_ready  - input handshake; a is captured on acceptance
//   a                   - input word (nominally one-hot)
//   out_valid, out_ready- output handshake; results held until accepted
//   z, zero, multi      - highest set index, no-bit flag, multi-hot flag
module au_encode_seq
    import au_encode_pkg::*;
#(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned SLICE = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2**WIDTH-1:0]   a,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      z,
    output logic                  zero,
    output logic                  multi
);

    localparam int unsigned AW = 2**WIDTH;
    localparam int unsigned N  = scan_count(WIDTH, SLICE);
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned LW = (SLICE > 1) ? $clog2(SLICE) : 1;

    localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
    localparam logic [1:0] S_SCAN = 2'(ST_SCAN);
    localparam logic [1:0] S_DONE = 2'(ST_DONE);

    if (!params_ok(WIDTH, SLICE)) begin : g_param_check
        $error("au_encode_seq: illegal WIDTH/SLICE combination");
    end

    logic [1:0]       state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [AW-1:0]    word, word_d;
    logic             found, found_d;
    logic             acc_multi, acc_multi_d;
    logic [WIDTH-1:0] idx, idx_d;
    logic             out_valid_d;
    logic [WIDTH-1:0] z_d;
    logic             zero_d, multi_d;

    logic [SLICE-1:0] chunk;
    logic [LW-1:0]    loc_idx;
    logic             chunk_any, chunk_multi;
    logic             accept;
    logic [WIDTH-1:0] idx_new;
    logic             found_new, multi_new;

    // DONE accepts a new word on the same edge as the output handshake.
    assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // Chunk mux: select bits [cnt*SLICE +: SLICE] of the captured word.
    assign chunk = SLICE'(word >> (32'(cnt) * SLICE));

    au_encode_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .chunk   (chunk),
        .idx_c   (loc_idx),
        .any_c   (chunk_any),
        .multi_c (chunk_multi)
    );

    // Accumulator update for the current chunk; max sum is 2**WIDTH-1.
    assign idx_new   = chunk_any ? (WIDTH'(32'(cnt) * SLICE) + WIDTH'(loc_idx)) : idx;
    assign found_new = found | chunk_any;
    assign multi_new = acc_multi | chunk_multi | (found & chunk_any);

    // Next-state and datapath.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        word_d      = word;
        found_d     = found;
        acc_multi_d = acc_multi;
        idx_d       = idx;
        out_valid_d = out_valid;
        z_d         = z;
        zero_d      = zero;
        multi_d     = multi;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    word_d      = a;
                    found_d     = 1'b0;
                    acc_multi_d = 1'b0;
                    idx_d       = '0;
                    cnt_d       = '0;
                    state_d     = S_SCAN;
                end
            end
            S_SCAN: begin
                out_valid_d = 1'b0;
                idx_d       = idx_new;
                found_d     = found_new;
                acc_multi_d = multi_new;
                if (cnt == CW'(N - 1)) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    z_d         = idx_new;
                    zero_d      = ~found_new;
                    multi_d     = multi_new;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (in_valid) begin
                        word_d      = a;
                        found_d     = 1'b0;
                        acc_multi_d = 1'b0;
                        idx_d       = '0;
                        cnt_d       = '0;
                        state_d     = S_SCAN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            word      <= '0;
            found     <= 1'b0;
            acc_multi <= 1'b0;
            idx       <= '0;
            out_valid <= 1'b0;
            z         <= '0;
            zero      <= 1'b0;
            multi     <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            word      <= word_d;
            found     <= found_d;
            acc_multi <= acc_multi_d;
            idx       <= idx_d;
            out_valid <= out_valid_d;
            z         <= z_d;
            zero      <= zero_d;
            multi     <= multi_d;
        end
    end

endmodule

// File: tb/tb_au_encode_seq.sv
// Scoreboard bench for au_encode_seq: three instances (SLICE = 2, 1, 8 at
// WIDTH = 3) share clock and reset; one is exercised at a time.
module tb_au_encode_seq;

    typedef struct {
        int         k;
        logic [2:0] z;
        bit         zero;
        bit         multi;
        longint     acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [2:0]      iv, ir, ov, ordy, zero_v, multi_v;
    logic [2:0][7:0] av;
    logic [2:0][2:0] zv;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned SL = (g == 0) ? 2 : ((g == 1) ? 1 : 8);
        au_encode_seq #(
            .WIDTH (3),
            .SLICE (SL)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .a         (av[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .z         (zv[g]),
            .zero      (zero_v[g]),
            .multi     (multi_v[g])
        );
    end

    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;
    exp_t   exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int n_of(input int k);
        case (k)
            0:       return 4;
            1:       return 8;
            default: return 1;
        endcase
    endfunction

    // Reference: highest set bit is floor(log2(w)); flags from popcount.
    function automatic exp_t model(input int k, input logic [7:0] w, input longint acc);
        exp_t e;
        e.k     = k;
        e.acc   = acc;
        e.zero  = (w == 8'h00);
        e.multi = ($countones(w) > 1);
        e.z     = (w == 8'h00) ? 3'd0 : 3'($clog2(int'(w) + 1) - 1);
        return e;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus; acceptance is known before the coming edge.
    task automatic step(input int k, input bit v, input logic [7:0] w,
                        input bit r, output bit acc);
        @(negedge clk);
        iv[k]   = v;
        av[k]   = w;
        ordy[k] = r;
        #1;
        acc = v && ir[k];
        if (acc) exp_q.push_back(model(k, w, cyc + 1));
    endtask

    task automatic send(input int k, input logic [7:0] w);
        bit acc = 1'b0;
        int n   = 0;
        while (!acc && n < 100) begin
            step(k, 1'b1, w, 1'b1, acc);
            n++;
        end
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    // Run until every pending result is consumed; in_ready must stay low in SCAN.
    task automatic drain(input int k);
        bit acc;
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step(k, 1'b0, 8'h00, 1'b1, acc);
            if (!ov[k] && exp_q.size() != 0) chk("in_ready_scan", ir[k], 0);
            n++;
        end
        if (n >= 100) begin
            chk("drain_timeout", 0, 1);
            exp_q.delete();
        end
    endtask

    task automatic check_reset();
        for (int k = 0; k < 3; k++) begin
            chk("rst_out_valid", ov[k], 0);
            chk("rst_z", zv[k], 0);
            chk("rst_zero", zero_v[k], 0);
            chk("rst_multi", multi_v[k], 0);
            chk("rst_in_ready", ir[k], 1);
        end
    endtask

    function automatic logic [7:0] rand_word();
        logic [7:0] w;
        case ($urandom_range(0, 3))
            0:       w = 8'h00;
            1, 2:    w = 8'(1 << $urandom_range(0, 7));
            default: w = 8'($urandom);
        endcase
        return w;
    endfunction

    // Monitor: latency on rising out_valid, stability under backpressure,
    // and in-order result comparison on each output handshake.
    bit         prev_ov [3];
    bit         hold    [3];
    logic [2:0] h_z     [3];
    bit         h_zero  [3];
    bit         h_multi [3];

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                for (int k = 0; k < 3; k++) begin
                    prev_ov[k] = 1'b0;
                    hold[k]    = 1'b0;
                end
            end else begin
                for (int k = 0; k < 3; k++) begin
                    if (ov[k] && !prev_ov[k]) begin
                        if (exp_q.size() == 0) chk("spurious_out_valid", 1, 0);
                        else chk("latency", cyc - exp_q[0].acc, n_of(k));
                    end
                    if (hold[k] && ov[k]) begin
                        chk("hold_z", zv[k], h_z[k]);
                        chk("hold_zero", zero_v[k], h_zero[k]);
                        chk("hold_multi", multi_v[k], h_multi[k]);
                    end
                    if (hold[k]) chk("hold_out_valid", ov[k], 1);
                    if (ov[k] && ordy[k]) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_result", 1, 0);
                        end else begin
                            exp_t e;
                            e = exp_q.pop_front();
                            chk("result_dut", k, e.k);
                            chk("result_z", zv[k], e.z);
                            chk("result_zero", zero_v[k], e.zero);
                            chk("result_multi", multi_v[k], e.multi);
                            chk("zero_multi_excl", zero_v[k] && multi_v[k], 0);
                        end
                    end
                    hold[k]    = ov[k] && !ordy[k];
                    h_z[k]     = zv[k];
                    h_zero[k]  = zero_v[k];
                    h_multi[k] = multi_v[k];
                    prev_ov[k] = ov[k];
                end
            end
        end
    end

    initial begin
        bit acc;
        int sent;
        int guard;
        int n;

        rst_n = 1'b0;
        iv    = '0;
        av    = '0;
        ordy  = '1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset();

        // Basic and flag cases on SLICE=2.
        send(0, 8'h20); drain(0);
        send(0, 8'h00); drain(0);
        send(0, 8'h41); drain(0);
        send(0, 8'h0C); drain(0);

        // Round trip of decoded indices on all three slice widths.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) begin
                send(k, 8'(1 << i));
                drain(k);
            end
        end

        // Backpressure, then a new word accepted on the handshake edge.
        send(0, 8'h41);
        n = 0;
        do begin
            step(0, 1'b0, 8'h00, 1'b0, acc);
            n++;
        end while (!ov[0] && n < 50);
        chk("bp_out_valid_seen", ov[0], 1);
        repeat (5) step(0, 1'b0, 8'h00, 1'b0, acc);
        step(0, 1'b1, 8'h02, 1'b1, acc);
        chk("bp_same_edge_accept", acc, 1);
        drain(0);

        // Reset during the second SCAN cycle discards the word.
        send(0, 8'h41);
        step(0, 1'b0, 8'h00, 1'b1, acc);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset();
        send(0, 8'h80); drain(0);

        // Random stress with random in_valid / out_ready.
        sent  = 0;
        guard = 0;
        while (sent < 1000 && guard < 30000) begin
            step(0, ($urandom_range(0, 2) != 0), rand_word(),
                 ($urandom_range(0, 3) != 0), acc);
            if (acc) sent++;
            guard++;
        end
        chk("stress_words_sent", sent, 1000);
        drain(0);
        repeat (3) step(0, 1'b0, 8'h00, 1'b1, acc);
        chk("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
